fifo_wr_arbiter: RTL

- Shares one fifo write port between NUM_REQ producers using round-robin arbitration.
- Sits directly in front of the fifo and drives its fifo_write and fifo_data_in.
- Keeps its own credit (occupancy) count from issued writes and the observed fifo_read strobe, so it never writes into a full fifo and never relies on the registered fifo_full flag.
- Outputs are registered, giving one cycle from accept to fifo write.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {RUN = 1'b0, FULL = 1'b1} arb_state_t;

    localparam int STAT_W = 16;

    // Next round-robin index with wrap at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted valid at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               any
);

    // Walk the ring starting at ptr and take the first requester found.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = int'(ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
            j = rr_next(j, NUM_REQ);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers.
// Tracks fifo occupancy itself from issued writes and observed reads, so it
// never writes into a full fifo. Outputs are registered (accept -> write in
// one cycle). Define FIFO_WR_ARBITER_STATS_EN to add per-requester grant
// counters and a stall counter.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int fifo_width = 8,
    parameter  int fifo_depth = 8,
    localparam int PW         = $clog2(NUM_REQ),
    localparam int OW         = $clog2(fifo_depth) + 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*fifo_width-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_write,
    output logic [fifo_width-1:0]         fifo_data_in,
    input  logic                          fifo_read,
    input  logic                          fifo_empty,
    output logic [OW-1:0]                 occupancy,
    output logic                          blocked,
    output logic [PW-1:0]                 grant_id
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]     grant_cnt,
    output logic [STAT_W-1:0]             stall_cnt
`endif
);

    arb_state_t           state, state_nxt;
    logic [PW-1:0]        ptr;
    logic [OW-1:0]        occ_nxt;
    logic                 can_accept, accept;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Credit after this cycle's write and read; a read of an empty count is ignored.
    assign occ_nxt    = occupancy + OW'(fifo_write) - OW'(fifo_read && (occupancy != '0));
    assign can_accept = occ_nxt < OW'(fifo_depth);
    assign accept     = rstn && can_accept && (state == RUN) && pick_any;
    assign req_ready  = accept ? pick_gnt : '0;
    assign blocked    = (state == FULL);

    // Block when the credit reaches the depth, release as soon as it drops.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (occ_nxt == OW'(fifo_depth)) state_nxt = FULL;
            FULL:    if (occ_nxt <  OW'(fifo_depth)) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Registered write port, credit, round-robin pointer and FSM state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= RUN;
            ptr          <= '0;
            occupancy    <= '0;
            fifo_write   <= 1'b0;
            fifo_data_in <= '0;
            grant_id     <= '0;
        end else begin
            state      <= state_nxt;
            occupancy  <= occ_nxt;
            fifo_write <= accept;
            if (accept) begin
                fifo_data_in <= req_data[int'(pick_idx)*fifo_width +: fifo_width];
                grant_id     <= pick_idx;
                ptr          <= PW'(rr_next(int'(pick_idx), NUM_REQ));
            end
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] gcnt;

    // Saturating per-requester transfer counts and blocked-with-demand cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gcnt      <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_valid[i] && req_ready[i] && gcnt[i] != '1)
                    gcnt[i] <= gcnt[i] + 1'b1;
            if ((|req_valid) && blocked && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign grant_cnt = gcnt;
`endif

`ifndef SYNTHESIS
    logic quiet_q;

    // Remember a cycle with no write and no read so the flag compare is settled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) quiet_q <= 1'b0;
        else       quiet_q <= !fifo_write && !fifo_read;
    end

    a_empty_consistent: assert property (@(posedge clk) disable iff (!rstn)
        quiet_q |-> ((occupancy == '0) == fifo_empty));
`endif

endmodule
